// File: rtl/tetris_input_ctrl.sv
// Keyboard-to-action front end for a Tetris core.
// Debounced make/break events in, single-cycle action pulses out.
module tetris_input_ctrl #(
  parameter int DAS_CYCLES = 16000000,
  parameter int ARR_CYCLES = 5000000,
  parameter int SDR_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       make_break,
  input  logic       key_event_valid,
  output logic       move_left,
  output logic       move_right,
  output logic       soft_drop,
  output logic       rotate_cw,
  output logic       rotate_ccw,
  output logic       hard_drop,
  output logic       hold,
  output logic       pause
);

  localparam int HMAX = (DAS_CYCLES > ARR_CYCLES) ?
                        DAS_CYCLES : ARR_CYCLES;
  localparam int HW = $clog2(HMAX) + 1;
  localparam int SW = $clog2(SDR_CYCLES) + 1;

  localparam logic [HW-1:0] DAS_LD = HW'(DAS_CYCLES - 1);
  localparam logic [HW-1:0] ARR_LD = HW'(ARR_CYCLES - 1);
  localparam logic [SW-1:0] SDR_LD = SW'(SDR_CYCLES - 1);

  typedef enum logic [3:0] {
    K_L, K_R, K_D, K_UP, K_X, K_Z, K_SP, K_C, K_ESC
  } key_e;

  typedef enum logic [1:0] {
    H_IDLE, H_DAS, H_REP
  } hstate_e;

  key_e       key;
  logic       hit;
  logic [8:0] held;
  logic       ev;
  logic       fresh;
  logic       brk;
  logic       is_h;
  logic       new_dir;
  logic       h_brk;
  logic       opp_held;

  hstate_e    hstate;
  logic       dir;
  logic [HW-1:0] hcnt;
  logic [SW-1:0] scnt;

  always_comb begin
    key = K_L;
    hit = 1'b1;
    unique case (1'b1)
      (scan_code == 8'h6B): key = K_L;
      (scan_code == 8'h74): key = K_R;
      (scan_code == 8'h72): key = K_D;
      (scan_code == 8'h75): key = K_UP;
      (scan_code == 8'h22): key = K_X;
      (scan_code == 8'h1A): key = K_Z;
      (scan_code == 8'h29): key = K_SP;
      (scan_code == 8'h21): key = K_C;
      (scan_code == 8'h76): key = K_ESC;
      default:              hit = 1'b0;
    endcase
  end

  assign ev       = key_event_valid & hit;
  assign fresh    = ev & make_break & ~held[key];
  assign brk      = ev & ~make_break;
  assign is_h     = (key == K_L) | (key == K_R);
  assign new_dir  = (key == K_R);
  assign opp_held = dir ? held[K_L] : held[K_R];
  assign h_brk    = brk & (hstate != H_IDLE) &
                    (key == (dir ? K_R : K_L));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
    end else if (ev) begin
      held[key] <= make_break;
    end
  end

  // dir: 0 = left, 1 = right; pulses are masked if already high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hstate     <= H_IDLE;
      dir        <= 1'b0;
      hcnt       <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      if (fresh & is_h) begin
        dir        <= new_dir;
        hcnt       <= DAS_LD;
        hstate     <= H_DAS;
        move_left  <= ~new_dir & ~move_left;
        move_right <= new_dir & ~move_right;
      end else if (h_brk) begin
        if (opp_held) begin
          dir        <= ~dir;
          hcnt       <= DAS_LD;
          hstate     <= H_DAS;
          move_left  <= dir & ~move_left;
          move_right <= ~dir & ~move_right;
        end else begin
          hcnt   <= '0;
          hstate <= H_IDLE;
        end
      end else begin
        unique case (hstate)
          H_DAS, H_REP: begin
            if (hcnt == '0) begin
              hcnt       <= ARR_LD;
              hstate     <= H_REP;
              move_left  <= ~dir & ~move_left;
              move_right <= dir & ~move_right;
            end else begin
              hcnt <= hcnt - HW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt      <= '0;
      soft_drop <= 1'b0;
    end else begin
      soft_drop <= 1'b0;
      if (fresh & (key == K_D)) begin
        scnt      <= SDR_LD;
        soft_drop <= ~soft_drop;
      end else if (brk & (key == K_D)) begin
        scnt <= '0;
      end else if (held[K_D]) begin
        if (scnt == '0) begin
          scnt      <= SDR_LD;
          soft_drop <= ~soft_drop;
        end else begin
          scnt <= scnt - SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rotate_cw  <= 1'b0;
      rotate_ccw <= 1'b0;
      hard_drop  <= 1'b0;
      hold       <= 1'b0;
      pause      <= 1'b0;
    end else begin
      rotate_cw  <= fresh & ((key == K_UP) | (key == K_X)) &
                    ~rotate_cw;
      rotate_ccw <= fresh & (key == K_Z) & ~rotate_ccw;
      hard_drop  <= fresh & (key == K_SP) & ~hard_drop;
      hold       <= fresh & (key == K_C) & ~hold;
      pause      <= fresh & (key == K_ESC) & ~pause;
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Random and directed bench for tetris_input_ctrl against
// a due-time behavioural model.
module tb_tetris_input_ctrl;

  localparam int DAS = 10;
  localparam int ARR = 4;
  localparam int SDR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       make_break = 1'b0;
  logic       key_event_valid = 1'b0;
  logic       move_left, move_right, soft_drop;
  logic       rotate_cw, rotate_ccw, hard_drop, hold, pause;

  tetris_input_ctrl #(
    .DAS_CYCLES(DAS),
    .ARR_CYCLES(ARR),
    .SDR_CYCLES(SDR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_code(scan_code),
    .make_break(make_break),
    .key_event_valid(key_event_valid),
    .move_left(move_left),
    .move_right(move_right),
    .soft_drop(soft_drop),
    .rotate_cw(rotate_cw),
    .rotate_ccw(rotate_ccw),
    .hard_drop(hard_drop),
    .hold(hold),
    .pause(pause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int total = 0;
  int ql[$];
  int qr[$];
  int qs[$];
  int qccw[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (move_left)  ql.push_back(cyc);
    if (move_right) qr.push_back(cyc);
    if (soft_drop)  qs.push_back(cyc);
    if (rotate_ccw) qccw.push_back(cyc);
    total = total + int'(move_left) + int'(move_right) +
            int'(soft_drop) + int'(rotate_cw) +
            int'(rotate_ccw) + int'(hard_drop) +
            int'(hold) + int'(pause);
  end

  // model state: active direction 0 none / 1 left / 2 right,
  // absolute cycle of next repeat pulse
  bit         mheld[256];
  int         act = 0;
  int         hdue = 0;
  int         sdue = 0;
  logic [7:0] exp_v = 8'h00;

  function automatic bit is_mapped(input logic [7:0] c);
    return c == 8'h6B || c == 8'h74 || c == 8'h72 ||
           c == 8'h75 || c == 8'h22 || c == 8'h1A ||
           c == 8'h29 || c == 8'h21 || c == 8'h76;
  endfunction

  always @(negedge clk) begin
    logic [7:0] got, want, raw;
    bit hev, sev;
    int nx;
    got = {move_left, move_right, soft_drop, rotate_cw,
           rotate_ccw, hard_drop, hold, pause};
    want = rst_n ? exp_v : 8'h00;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL out_vec cycle=%0d got=%b want=%b",
               cyc, got, want);
    end
    if (!rst_n) begin
      foreach (mheld[i]) mheld[i] = 1'b0;
      act = 0;
      exp_v = 8'h00;
    end else begin
      raw = 8'h00;
      hev = 1'b0;
      sev = 1'b0;
      nx = cyc + 1;
      if (key_event_valid && is_mapped(scan_code)) begin
        if (make_break && !mheld[scan_code]) begin
          case (scan_code)
            8'h6B: begin
              act = 1; hdue = nx + DAS; raw[7] = 1; hev = 1;
            end
            8'h74: begin
              act = 2; hdue = nx + DAS; raw[6] = 1; hev = 1;
            end
            8'h72: begin
              sdue = nx + SDR; raw[5] = 1; sev = 1;
            end
            8'h75, 8'h22: raw[4] = 1;
            8'h1A: raw[3] = 1;
            8'h29: raw[2] = 1;
            8'h21: raw[1] = 1;
            default: raw[0] = 1;
          endcase
        end
        if (!make_break) begin
          if (scan_code == 8'h72) sev = 1;
          if ((act == 1 && scan_code == 8'h6B) ||
              (act == 2 && scan_code == 8'h74)) begin
            hev = 1;
            if (act == 1 && mheld[8'h74]) begin
              act = 2; raw[6] = 1; hdue = nx + DAS;
            end else if (act == 2 && mheld[8'h6B]) begin
              act = 1; raw[7] = 1; hdue = nx + DAS;
            end else begin
              act = 0;
            end
          end
        end
        mheld[scan_code] = make_break;
      end
      if (!hev && act != 0 && hdue == nx) begin
        if (act == 1) raw[7] = 1;
        else raw[6] = 1;
        hdue = hdue + ARR;
      end
      if (!sev && mheld[8'h72] && sdue == nx) begin
        raw[5] = 1;
        sdue = sdue + SDR;
      end
      exp_v = raw & ~exp_v;
    end
  end

  task automatic chk(input string name, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic m);
    scan_code = c;
    make_break = m;
    key_event_valid = 1'b1;
    @(posedge clk);
    #1;
    key_event_valid = 1'b0;
    scan_code = 8'h00;
    make_break = 1'b0;
  endtask

  task automatic clr();
    ql.delete();
    qr.delete();
    qs.delete();
    qccw.delete();
    total = 0;
  endtask

  logic [7:0] codes [14];

  initial begin
    int t, t0;
    codes = '{8'h6B, 8'h6B, 8'h74, 8'h74, 8'h72, 8'h72,
              8'h75, 8'h22, 8'h1A, 8'h29, 8'h21, 8'h76,
              8'h1C, 8'h00};
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // left held with typematic repeats
    clr();
    t = cyc;
    send(8'h6B, 1'b1);
    tick(4);
    send(8'h6B, 1'b1);
    tick(3);
    send(8'h6B, 1'b1);
    tick(10);
    send(8'h6B, 1'b0);
    tick(3);
    chk("das_count", ql.size(), 4);
    if (ql.size() == 4) begin
      chk("das_p0", ql[0], t + 1);
      chk("das_p1", ql[1], t + 11);
      chk("das_p2", ql[2], t + 15);
      chk("das_p3", ql[3], t + 19);
    end
    tick(3);

    // last press wins, then fall back to held left
    clr();
    t0 = cyc;
    send(8'h6B, 1'b1);
    tick(2);
    t = cyc;
    send(8'h74, 1'b1);
    tick(5);
    send(8'h74, 1'b0);
    tick(12);
    chk("sw_r_count", qr.size(), 1);
    if (qr.size() == 1) chk("sw_r0", qr[0], t + 1);
    chk("sw_l_count", ql.size(), 3);
    if (ql.size() == 3) begin
      chk("sw_l0", ql[0], t0 + 1);
      chk("sw_l1", ql[1], t + 7);
      chk("sw_l2", ql[2], t + 17);
    end
    send(8'h6B, 1'b0);
    tick(3);

    // one-shot rotate, unmapped code ignored
    clr();
    send(8'h1A, 1'b1);
    tick(2);
    send(8'h1A, 1'b1);
    tick(2);
    send(8'h1A, 1'b0);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    tick(3);
    chk("ccw_count", qccw.size(), 1);
    chk("ccw_total", total, 1);

    // soft drop alongside left auto-repeat
    clr();
    t = cyc;
    send(8'h72, 1'b1);
    send(8'h6B, 1'b1);
    tick(18);
    chk("sd_count", qs.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < qs.size()) chk("sd_p", qs[i], t + 1 + 3 * i);
    chk("sdl_count", ql.size(), 3);
    if (ql.size() == 3) begin
      chk("sdl_p0", ql[0], t + 2);
      chk("sdl_p1", ql[1], t + 12);
      chk("sdl_p2", ql[2], t + 16);
    end
    send(8'h72, 1'b0);
    send(8'h6B, 1'b0);
    tick(3);

    // reset in REPEAT discards held state
    send(8'h74, 1'b1);
    tick(14);
    rst_n = 1'b0;
    clr();
    tick(1);
    rst_n = 1'b1;
    send(8'h74, 1'b0);
    tick(20);
    chk("rst_total", total, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        send(codes[$urandom_range(0, 13)],
             $urandom_range(0, 2) != 0);
      end else begin
        tick(1);
      end
    end
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
